// File: rtl/aes_kat_bist_if.sv
// rtl/aes_kat_bist_if.sv - vector/ciphertext bus between the KAT BIST and the aes_128 core
//
// Signals:
//   aes_state  plaintext presented to the core
//   aes_key    key presented to the core
//   aes_out    ciphertext returned by the core
// Modports:
//   master     BIST side: drives aes_state/aes_key, reads aes_out
//   slave      core side: reads aes_state/aes_key, drives aes_out
interface aes_kat_bist_if;
   logic [127:0] aes_state;
   logic [127:0] aes_key;
   logic [127:0] aes_out;

   modport master (output aes_state, output aes_key, input aes_out);
   modport slave  (input aes_state, input aes_key, output aes_out);
endinterface

// File: rtl/aes_kat_bist.sv
// rtl/aes_kat_bist.sv - known-answer self-test engine for the pipelined aes_128 core
//
// Parameters:
//   LATENCY        core latency in edges, sample edge to result edge (1..63)
//   NUM_VEC        ROM vectors replayed per pass (1..5)
//   GAP            idle cycles between issued vectors (0..15)
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          one-cycle pulse, begins a run when idle
//   loop           sampled with start, repeat passes until stop
//   stop           level, ends a loop run at the next pass boundary
//   core           master side of the core bus (aes_state/aes_key out, aes_out in)
//   busy           run in progress
//   done           one-cycle pulse at the end of a run or pass
//   pass           sticky, last completed pass had no mismatches
//   fail_count     mismatches in the current/last run, saturating
//   first_fail_idx ROM index of the first mismatch, 7 when none
//   pass_count     completed passes in the current run, wrapping
module aes_kat_bist #(
   parameter int LATENCY = 21,
   parameter int NUM_VEC = 5,
   parameter int GAP     = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 loop,
   input  logic                 stop,
   aes_kat_bist_if.master       core,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [7:0]           fail_count,
   output logic [2:0]           first_fail_idx,
   output logic [15:0]          pass_count
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_GAP, DRAIN, DONE} state_t;

   localparam logic [2:0] LAST_IDX = 3'(NUM_VEC - 1);
   localparam logic [2:0] VEC_CNT  = 3'(NUM_VEC);
   localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   state_t       state;
   logic [2:0]   issue_idx;
   logic [3:0]   gap_cnt;
   logic [2:0]   chk_cnt;
   logic         loop_mode;
   logic [127:0] state_q;
   logic [127:0] key_q;

   // Tag pipeline: follows each issued vector through the core so the
   // returning ciphertext can be matched to its ROM entry.
   logic         tag_v   [LATENCY];
   logic [2:0]   tag_idx [LATENCY];

   logic         chk_v;
   logic [2:0]   chk_idx;
   logic         mismatch;

   function automatic logic [127:0] rom_state(input logic [2:0] i);
      case (i)
         3'd0:    return 128'h3243f6a8885a308d313198a2e0370734;
         3'd1:    return 128'h00112233445566778899aabbccddeeff;
         3'd4:    return 128'h1;
         default: return 128'h0;
      endcase
   endfunction

   function automatic logic [127:0] rom_key(input logic [2:0] i);
      case (i)
         3'd0:    return 128'h2b7e151628aed2a6abf7158809cf4f3c;
         3'd1:    return 128'h000102030405060708090a0b0c0d0e0f;
         3'd3:    return 128'h1;
         default: return 128'h0;
      endcase
   endfunction

   function automatic logic [127:0] rom_ct(input logic [2:0] i);
      case (i)
         3'd0:    return 128'h3925841d02dc09fbdc118597196a0b32;
         3'd1:    return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
         3'd2:    return 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
         3'd3:    return 128'h0545aad56da2a97c3663d1432a3d1c84;
         3'd4:    return 128'h58e2fccefa7e3061367f1d57a4e7455a;
         default: return 128'h0;
      endcase
   endfunction

   assign core.aes_state = state_q;
   assign core.aes_key   = key_q;

   assign chk_v    = tag_v[LATENCY-1];
   assign chk_idx  = tag_idx[LATENCY-1];
   assign mismatch = chk_v && (core.aes_out != rom_ct(chk_idx));

   // A tag enters on the same edge the core samples the vector, so the
   // output stage lines up with aes_out exactly LATENCY edges later.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LATENCY; i++) begin
            tag_v[i]   <= 1'b0;
            tag_idx[i] <= 3'd0;
         end
      end else begin
         tag_v[0]   <= (state == ISSUE);
         tag_idx[0] <= issue_idx;
         for (int i = 1; i < LATENCY; i++) begin
            tag_v[i]   <= tag_v[i-1];
            tag_idx[i] <= tag_idx[i-1];
         end
      end
   end

   // The vector registers are loaded on the edge that enters ISSUE, so the
   // core sees ROM data exactly while the FSM sits in ISSUE and zero otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         issue_idx      <= 3'd0;
         gap_cnt        <= 4'd0;
         chk_cnt        <= 3'd0;
         loop_mode      <= 1'b0;
         state_q        <= '0;
         key_q          <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         fail_count     <= 8'd0;
         first_fail_idx <= 3'd7;
         pass_count     <= 16'd0;
      end else begin
         done <= 1'b0;

         if (chk_v) begin
            chk_cnt <= chk_cnt + 3'd1;
            if (mismatch) begin
               if (fail_count != 8'hff)
                  fail_count <= fail_count + 8'd1;
               if (first_fail_idx == 3'd7)
                  first_fail_idx <= chk_idx;
            end
         end

         case (state)
            IDLE: begin
               if (start) begin
                  state          <= ISSUE;
                  busy           <= 1'b1;
                  loop_mode      <= loop;
                  issue_idx      <= 3'd0;
                  chk_cnt        <= 3'd0;
                  fail_count     <= 8'd0;
                  first_fail_idx <= 3'd7;
                  pass_count     <= 16'd0;
                  state_q        <= rom_state(3'd0);
                  key_q          <= rom_key(3'd0);
               end
            end
            ISSUE: begin
               if (issue_idx == LAST_IDX) begin
                  state   <= DRAIN;
                  state_q <= '0;
                  key_q   <= '0;
               end else if (GAP > 0) begin
                  state   <= WAIT_GAP;
                  gap_cnt <= 4'd0;
                  state_q <= '0;
                  key_q   <= '0;
               end else begin
                  issue_idx <= issue_idx + 3'd1;
                  state_q   <= rom_state(issue_idx + 3'd1);
                  key_q     <= rom_key(issue_idx + 3'd1);
               end
            end
            WAIT_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state     <= ISSUE;
                  issue_idx <= issue_idx + 3'd1;
                  state_q   <= rom_state(issue_idx + 3'd1);
                  key_q     <= rom_key(issue_idx + 3'd1);
               end else begin
                  gap_cnt <= gap_cnt + 4'd1;
               end
            end
            DRAIN: begin
               // All issues are out; the pass ends once every tag has been checked.
               if (chk_cnt == VEC_CNT) begin
                  state      <= DONE;
                  done       <= 1'b1;
                  pass       <= (fail_count == 8'd0);
                  pass_count <= pass_count + 16'd1;
               end
            end
            DONE: begin
               // Fail statistics deliberately carry over into the next loop pass.
               if (loop_mode && !stop) begin
                  state     <= ISSUE;
                  issue_idx <= 3'd0;
                  chk_cnt   <= 3'd0;
                  state_q   <= rom_state(3'd0);
                  key_q     <= rom_key(3'd0);
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_kat_bist.sv
// tb/tb_aes_kat_bist.sv - scoreboard testbench for aes_kat_bist with behavioural core models
module tb_aes_kat_bist;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [127:0] tb_pt  [5] = '{128'h3243f6a8885a308d313198a2e0370734,
                                128'h00112233445566778899aabbccddeeff,
                                128'h0, 128'h0, 128'h1};
   logic [127:0] tb_key [5] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                                128'h000102030405060708090a0b0c0d0e0f,
                                128'h0, 128'h1, 128'h0};
   logic [127:0] tb_ct  [5] = '{128'h3925841d02dc09fbdc118597196a0b32,
                                128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                                128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                                128'h0545aad56da2a97c3663d1432a3d1c84,
                                128'h58e2fccefa7e3061367f1d57a4e7455a};

   typedef struct {
      int          done_cyc;
      logic        pass;
      logic [7:0]  fc;
      logic [2:0]  ffi;
      logic [15:0] pc;
   } exp_t;
   exp_t sb_q[$];

   // mode 0: correct core, 1: flip bit 0 of vector 2, 2: constant zero
   function automatic logic [127:0] model_ct(input logic [127:0] pt, input logic [127:0] k, input int mode);
      logic [127:0] r;
      r = {4{32'hdeadbeef}};
      if (mode == 2) return '0;
      for (int j = 0; j < 5; j++) begin
         if (pt == tb_pt[j] && k == tb_key[j]) begin
            r = tb_ct[j];
            if (mode == 1 && j == 2) r[0] = ~r[0];
         end
      end
      return r;
   endfunction

   // Instance A: LATENCY=21, NUM_VEC=5, GAP=0
   logic start_a = 1'b0, loop_a = 1'b0, stop_a = 1'b0;
   logic busy_a, done_a, pass_a;
   logic [7:0] fc_a;
   logic [2:0] ffi_a;
   logic [15:0] pc_a;
   int mode_a = 0;
   logic [127:0] pipe_a [21];
   aes_kat_bist_if bus_a();

   aes_kat_bist #(.LATENCY(21), .NUM_VEC(5), .GAP(0)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .loop(loop_a), .stop(stop_a),
      .core(bus_a), .busy(busy_a), .done(done_a), .pass(pass_a),
      .fail_count(fc_a), .first_fail_idx(ffi_a), .pass_count(pc_a));

   always @(posedge clk) begin
      pipe_a[0] <= model_ct(bus_a.aes_state, bus_a.aes_key, mode_a);
      for (int i = 1; i < 21; i++) pipe_a[i] <= pipe_a[i-1];
   end
   assign bus_a.aes_out = pipe_a[20];

   // Instance B: LATENCY=4, NUM_VEC=3, GAP=3
   logic start_b = 1'b0, loop_b = 1'b0, stop_b = 1'b0;
   logic busy_b, done_b, pass_b;
   logic [7:0] fc_b;
   logic [2:0] ffi_b;
   logic [15:0] pc_b;
   logic [127:0] pipe_b [4];
   aes_kat_bist_if bus_b();

   aes_kat_bist #(.LATENCY(4), .NUM_VEC(3), .GAP(3)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .loop(loop_b), .stop(stop_b),
      .core(bus_b), .busy(busy_b), .done(done_b), .pass(pass_b),
      .fail_count(fc_b), .first_fail_idx(ffi_b), .pass_count(pc_b));

   always @(posedge clk) begin
      pipe_b[0] <= model_ct(bus_b.aes_state, bus_b.aes_key, 0);
      for (int i = 1; i < 4; i++) pipe_b[i] <= pipe_b[i-1];
   end
   assign bus_b.aes_out = pipe_b[3];

   // Pulses start on A; s is the number of the edge that samples it.
   task automatic run_a(input logic lp, output int s);
      @(negedge clk);
      start_a = 1'b1;
      loop_a  = lp;
      @(posedge clk);
      #1;
      s = cyc;
      start_a = 1'b0;
   endtask

   task automatic wait_done_a(input int budget, output int dc);
      dc = -1;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (done_a) begin
            dc = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({busy_a, done_a, pass_a, fc_a, ffi_a, pc_a} !== {3'b000, 8'd0, 3'd7, 16'd0}) begin
         n_fail++;
         $display("FAIL reset_a: busy=%b done=%b pass=%b fc=%0d ffi=%0d pc=%0d, expected 0 0 0 0 7 0",
                  busy_a, done_a, pass_a, fc_a, ffi_a, pc_a);
      end
      n_checks++;
      if ({busy_b, done_b, pass_b, fc_b, ffi_b, pc_b} !== {3'b000, 8'd0, 3'd7, 16'd0}) begin
         n_fail++;
         $display("FAIL reset_b: busy=%b done=%b pass=%b fc=%0d ffi=%0d pc=%0d, expected 0 0 0 0 7 0",
                  busy_b, done_b, pass_b, fc_b, ffi_b, pc_b);
      end
      n_checks++;
      if (bus_a.aes_state !== 128'h0 || bus_a.aes_key !== 128'h0) begin
         n_fail++;
         $display("FAIL reset_bus: state=%h key=%h, expected zero", bus_a.aes_state, bus_a.aes_key);
      end
   endtask

   task automatic test_clean_run();
      int s, dc;
      exp_t e;
      mode_a = 0;
      run_a(1'b0, s);
      sb_q.push_back('{s + 27, 1'b1, 8'd0, 3'd7, 16'd1});
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_checks++;
         if (bus_a.aes_state !== tb_pt[k] || bus_a.aes_key !== tb_key[k] || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL clean_issue%0d: state=%h key=%h busy=%b, expected %h %h 1",
                     k, bus_a.aes_state, bus_a.aes_key, busy_a, tb_pt[k], tb_key[k]);
         end
      end
      wait_done_a(60, dc);
      e = sb_q.pop_front();
      n_checks++;
      if (dc !== e.done_cyc) begin
         n_fail++;
         $display("FAIL clean_done_cycle: got %0d, expected %0d", dc, e.done_cyc);
      end
      n_checks++;
      if ({pass_a, fc_a, ffi_a, pc_a} !== {e.pass, e.fc, e.ffi, e.pc}) begin
         n_fail++;
         $display("FAIL clean_result: pass=%b fc=%0d ffi=%0d pc=%0d, expected %b %0d %0d %0d",
                  pass_a, fc_a, ffi_a, pc_a, e.pass, e.fc, e.ffi, e.pc);
      end
      @(negedge clk);
      n_checks++;
      if (busy_a !== 1'b0 || done_a !== 1'b0) begin
         n_fail++;
         $display("FAIL clean_idle: busy=%b done=%b, expected 0 0", busy_a, done_a);
      end
   endtask

   task automatic test_bit_corrupt();
      int s, dc;
      exp_t e;
      mode_a = 1;
      run_a(1'b0, s);
      sb_q.push_back('{s + 27, 1'b0, 8'd1, 3'd2, 16'd1});
      wait_done_a(60, dc);
      e = sb_q.pop_front();
      n_checks++;
      if (dc !== e.done_cyc || {pass_a, fc_a, ffi_a, pc_a} !== {e.pass, e.fc, e.ffi, e.pc}) begin
         n_fail++;
         $display("FAIL corrupt_result: done@%0d pass=%b fc=%0d ffi=%0d pc=%0d, expected done@%0d %b %0d %0d %0d",
                  dc, pass_a, fc_a, ffi_a, pc_a, e.done_cyc, e.pass, e.fc, e.ffi, e.pc);
      end
      mode_a = 0;
   endtask

   task automatic test_gap();
      int s, dc;
      exp_t e;
      logic [127:0] exp_st;
      @(negedge clk);
      start_b = 1'b1;
      @(posedge clk);
      #1;
      s = cyc;
      start_b = 1'b0;
      sb_q.push_back('{s + 14, 1'b1, 8'd0, 3'd7, 16'd1});
      dc = -1;
      for (int c = 0; c < 40 && dc < 0; c++) begin
         @(negedge clk);
         if (done_b) dc = cyc;
         if (cyc - s <= 12) begin
            exp_st = ((cyc - s) % 4 == 0) ? tb_pt[(cyc - s) / 4] : 128'h0;
            n_checks++;
            if (bus_b.aes_state !== exp_st) begin
               n_fail++;
               $display("FAIL gap_state@s+%0d: got %h, expected %h", cyc - s, bus_b.aes_state, exp_st);
            end
         end
      end
      e = sb_q.pop_front();
      n_checks++;
      if (dc !== e.done_cyc || {pass_b, fc_b, ffi_b, pc_b} !== {e.pass, e.fc, e.ffi, e.pc}) begin
         n_fail++;
         $display("FAIL gap_result: done@%0d pass=%b fc=%0d ffi=%0d pc=%0d, expected done@%0d %b %0d %0d %0d",
                  dc, pass_b, fc_b, ffi_b, pc_b, e.done_cyc, e.pass, e.fc, e.ffi, e.pc);
      end
   endtask

   task automatic test_loop();
      int s, dc;
      exp_t e;
      mode_a = 0;
      run_a(1'b1, s);
      for (int p = 0; p < 3; p++)
         sb_q.push_back('{s + 27 + 28 * p, 1'b1, 8'd0, 3'd7, 16'(p + 1)});
      for (int p = 0; p < 3; p++) begin
         wait_done_a(80, dc);
         e = sb_q.pop_front();
         n_checks++;
         if (dc !== e.done_cyc || {pass_a, fc_a, ffi_a, pc_a} !== {e.pass, e.fc, e.ffi, e.pc}) begin
            n_fail++;
            $display("FAIL loop_pass%0d: done@%0d pass=%b fc=%0d ffi=%0d pc=%0d, expected done@%0d %b %0d %0d %0d",
                     p, dc, pass_a, fc_a, ffi_a, pc_a, e.done_cyc, e.pass, e.fc, e.ffi, e.pc);
         end
         if (p == 1) begin
            repeat (5) @(negedge clk);
            stop_a = 1'b1;
         end
      end
      @(negedge clk);
      n_checks++;
      if (busy_a !== 1'b0) begin
         n_fail++;
         $display("FAIL loop_stop_busy: busy=%b, expected 0", busy_a);
      end
      wait_done_a(70, dc);
      n_checks++;
      if (dc !== -1) begin
         n_fail++;
         $display("FAIL loop_extra_done: done seen at %0d, expected none", dc);
      end
      stop_a = 1'b0;
      loop_a = 1'b0;
   endtask

   task automatic test_busy_start();
      int s, dc;
      exp_t e;
      mode_a = 2;
      run_a(1'b0, s);
      sb_q.push_back('{s + 27, 1'b0, 8'd5, 3'd0, 16'd1});
      repeat (10) @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      wait_done_a(60, dc);
      e = sb_q.pop_front();
      n_checks++;
      if (dc !== e.done_cyc || {pass_a, fc_a, ffi_a, pc_a} !== {e.pass, e.fc, e.ffi, e.pc}) begin
         n_fail++;
         $display("FAIL zero_result: done@%0d pass=%b fc=%0d ffi=%0d pc=%0d, expected done@%0d %b %0d %0d %0d",
                  dc, pass_a, fc_a, ffi_a, pc_a, e.done_cyc, e.pass, e.fc, e.ffi, e.pc);
      end
      wait_done_a(40, dc);
      n_checks++;
      if (dc !== -1 || busy_a !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_start_ignored: extra done at %0d busy=%b, expected none and 0", dc, busy_a);
      end
      mode_a = 0;
   endtask

   task automatic test_reset_drain();
      int s, dc;
      exp_t e;
      mode_a = 2;
      run_a(1'b0, s);
      repeat (24) @(negedge clk);
      rst = 1'b1;
      mode_a = 0;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if ({busy_a, done_a, pass_a, fc_a, ffi_a} !== {3'b000, 8'd0, 3'd7}) begin
         n_fail++;
         $display("FAIL drain_reset: busy=%b done=%b pass=%b fc=%0d ffi=%0d, expected 0 0 0 0 7",
                  busy_a, done_a, pass_a, fc_a, ffi_a);
      end
      wait_done_a(40, dc);
      n_checks++;
      if (dc !== -1) begin
         n_fail++;
         $display("FAIL drain_no_done: done seen at %0d, expected none", dc);
      end
      run_a(1'b0, s);
      sb_q.push_back('{s + 27, 1'b1, 8'd0, 3'd7, 16'd1});
      wait_done_a(60, dc);
      e = sb_q.pop_front();
      n_checks++;
      if (dc !== e.done_cyc || {pass_a, fc_a, ffi_a, pc_a} !== {e.pass, e.fc, e.ffi, e.pc}) begin
         n_fail++;
         $display("FAIL post_reset_run: done@%0d pass=%b fc=%0d ffi=%0d pc=%0d, expected done@%0d %b %0d %0d %0d",
                  dc, pass_a, fc_a, ffi_a, pc_a, e.done_cyc, e.pass, e.fc, e.ffi, e.pc);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_clean_run();
      test_bit_corrupt();
      test_gap();
      test_loop();
      test_busy_start();
      test_reset_drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
